// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched: arbitrates write and read bursts between a streaming
// write FIFO, a ring buffer in external memory and a downstream read FIFO.
// One burst is outstanding at a time; reads and writes alternate on ties.
module ddr_burst_sched #(
  parameter int ADDR_BITS     = 24,
  parameter int BURST_LEN     = 64,
  parameter int BASE_ADDR     = 0,
  parameter int REGION_WORDS  = 1024,
  parameter int RD_FIFO_DEPTH = 512,
  parameter int TIMEOUT       = 4095
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [9:0]           wr_fifo_rdusedw,
  input  logic [9:0]           rd_fifo_wrusedw,
  output logic                 rd_burst_req,
  output logic                 wr_burst_req,
  output logic [9:0]           rd_burst_len,
  output logic [9:0]           wr_burst_len,
  output logic [ADDR_BITS-1:0] rd_burst_addr,
  output logic [ADDR_BITS-1:0] wr_burst_addr,
  input  logic                 rd_burst_finish,
  input  logic                 wr_burst_finish,
  output logic [ADDR_BITS:0]   stored_words,
  output logic                 mem_full,
  output logic                 mem_empty,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int SW = ADDR_BITS + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [9:0]           BL_F     = 10'(BURST_LEN);
  localparam logic [9:0]           RD_LIMIT = 10'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [SW-1:0]        BL_S     = SW'(BURST_LEN);
  localparam logic [SW-1:0]        REGION_S = SW'(REGION_WORDS);
  localparam logic [SW-1:0]        WR_LIMIT = SW'(REGION_WORDS - BURST_LEN);
  localparam logic [ADDR_BITS-1:0] BL_A     = ADDR_BITS'(BURST_LEN);
  localparam logic [ADDR_BITS-1:0] REGION_A = ADDR_BITS'(REGION_WORDS);
  localparam logic [ADDR_BITS-1:0] BASE_A   = ADDR_BITS'(BASE_ADDR);
  localparam logic [CW-1:0]        TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_BITS-1:0]   wr_ptr;
  logic [ADDR_BITS-1:0]   rd_ptr;
  logic [CW-1:0]          cnt;
  logic                   last_grant_rd;
  logic                   flush_pend;
  logic                   wr_ok;
  logic                   rd_ok;
  logic                   grant_wr;
  logic                   grant_rd;
  logic                   wr_done;
  logic                   rd_done;
  logic                   tmo;
  logic                   flush_now;

  // Ring pointer step: advance one burst and wrap at the end of the region.
  function automatic logic [ADDR_BITS-1:0] advance(input logic [ADDR_BITS-1:0] p);
    logic [ADDR_BITS-1:0] inc;
    inc = p + BL_A;
    advance = (inc == REGION_A) ? '0 : inc;
  endfunction

  assign wr_ok = enable && (wr_fifo_rdusedw >= BL_F) && (stored_words <= WR_LIMIT);
  assign rd_ok = enable && (stored_words >= BL_S) && (rd_fifo_wrusedw <= RD_LIMIT);

  // State, ring pointers, occupancy, timeout counter and pending flush.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      stored_words  <= '0;
      cnt           <= '0;
      last_grant_rd <= 1'b1;
      flush_pend    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state != IDLE && state_nxt != IDLE) ? cnt + 1'b1 : '0;
      if (grant_wr) last_grant_rd <= 1'b0;
      if (grant_rd) last_grant_rd <= 1'b1;
      if (tmo) timeout_err <= 1'b1;
      if (flush_now) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        stored_words <= '0;
        flush_pend   <= 1'b0;
      end else begin
        if (wr_done) begin
          wr_ptr       <= advance(wr_ptr);
          stored_words <= stored_words + BL_S;
        end
        if (rd_done) begin
          rd_ptr       <= advance(rd_ptr);
          stored_words <= stored_words - BL_S;
        end
        if (flush && state != IDLE) flush_pend <= 1'b1;
      end
    end
  end

  // Next state: flush takes precedence in IDLE, then round-robin arbitration.
  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    tmo       = 1'b0;
    flush_now = 1'b0;
    case (state)
      IDLE: begin
        if (flush || flush_pend) begin
          flush_now = 1'b1;
        end else if (wr_ok && (!rd_ok || last_grant_rd)) begin
          state_nxt = WR_BURST;
          grant_wr  = 1'b1;
        end else if (rd_ok) begin
          state_nxt = RD_BURST;
          grant_rd  = 1'b1;
        end
      end
      WR_BURST: begin
        if (wr_burst_finish) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_BURST: begin
        if (rd_burst_finish) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state and pointers only.
  always_comb begin
    wr_burst_req  = (state == WR_BURST);
    rd_burst_req  = (state == RD_BURST);
    busy          = (state != IDLE);
    wr_burst_len  = BL_F;
    rd_burst_len  = BL_F;
    wr_burst_addr = BASE_A + wr_ptr;
    rd_burst_addr = BASE_A + rd_ptr;
    mem_full      = (stored_words == REGION_S);
    mem_empty     = (stored_words == '0);
  end

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Testbench for ddr_burst_sched: engine model answering bursts after a set
// delay, a burst scoreboard, a table of idle-start vectors and hand sequences.
`timescale 1ns/1ps
module tb_ddr_burst_sched;

  logic        mem_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic [9:0]  wr_fifo_rdusedw;
  logic [9:0]  rd_fifo_wrusedw;
  logic        rd_burst_req;
  logic        wr_burst_req;
  logic [9:0]  rd_burst_len;
  logic [9:0]  wr_burst_len;
  logic [23:0] rd_burst_addr;
  logic [23:0] wr_burst_addr;
  logic        rd_burst_finish;
  logic        wr_burst_finish;
  logic [24:0] stored_words;
  logic        mem_full;
  logic        mem_empty;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    bit          is_wr;
    logic [23:0] addr;
  } burst_t;

  typedef struct {
    logic        en;
    logic [9:0]  wu;
    logic [9:0]  ru;
    logic        exp_wr;
    logic [24:0] exp_stored;
  } vec_t;

  burst_t sb[$];
  vec_t   vecs[6];
  int     n_checks = 0;
  int     n_pass = 0;
  int     eng_delay = 3;
  int     eng_age = 0;

  ddr_burst_sched dut (
    .mem_clk         (mem_clk),
    .rst             (rst),
    .enable          (enable),
    .flush           (flush),
    .wr_fifo_rdusedw (wr_fifo_rdusedw),
    .rd_fifo_wrusedw (rd_fifo_wrusedw),
    .rd_burst_req    (rd_burst_req),
    .wr_burst_req    (wr_burst_req),
    .rd_burst_len    (rd_burst_len),
    .wr_burst_len    (wr_burst_len),
    .rd_burst_addr   (rd_burst_addr),
    .wr_burst_addr   (wr_burst_addr),
    .rd_burst_finish (rd_burst_finish),
    .wr_burst_finish (wr_burst_finish),
    .stored_words    (stored_words),
    .mem_full        (mem_full),
    .mem_empty       (mem_empty),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input logic en, input logic [9:0] wu, input logic [9:0] ru);
    enable          = en;
    wr_fifo_rdusedw = wu;
    rd_fifo_wrusedw = ru;
  endtask

  task automatic pushExp(input bit is_wr, input int addr);
    burst_t e;
    e.is_wr = is_wr;
    e.addr  = 24'(addr);
    sb.push_back(e);
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       probe = !busy;
      1:       probe = wr_burst_req;
      2:       probe = rd_burst_req;
      3:       probe = wr_burst_finish;
      4:       probe = rd_burst_finish;
      5:       probe = (sb.size() == 0);
      6:       probe = mem_full;
      default: probe = 1'b0;
    endcase
  endfunction

  task automatic waitUntil(input int sel, input string name, input int limit);
    int n = 0;
    while (!probe(sel) && n < limit) begin
      @(negedge mem_clk);
      n++;
    end
    checkOutput(name, 32'(probe(sel)), 1);
  endtask

  task automatic doReset();
    rst   = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 10'd0, 10'd0);
    @(negedge mem_clk);
    @(negedge mem_clk);
    rst = 1'b0;
  endtask

  // Engine model: finish pulse for the active direction eng_delay cycles after req.
  initial begin
    wr_burst_finish = 1'b0;
    rd_burst_finish = 1'b0;
    forever begin
      @(posedge mem_clk);
      #2;
      wr_burst_finish = 1'b0;
      rd_burst_finish = 1'b0;
      if (wr_burst_req || rd_burst_req) begin
        eng_age++;
        if (eng_delay > 0 && eng_age == eng_delay) begin
          wr_burst_finish = wr_burst_req;
          rd_burst_finish = rd_burst_req;
        end
      end else begin
        eng_age = 0;
      end
    end
  end

  // Scoreboard monitor: each new request must match the next expected burst.
  initial begin
    logic   prev_wr;
    logic   prev_rd;
    burst_t e;
    prev_wr = 1'b0;
    prev_rd = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (rst === 1'b0) begin
        checkOutput("req_exclusive", 32'(wr_burst_req & rd_burst_req), 0);
        if ((wr_burst_req && !prev_wr) || (rd_burst_req && !prev_rd)) begin
          checkOutput("burst_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("burst_dir", 32'(wr_burst_req), 32'(e.is_wr));
            checkOutput("burst_addr", wr_burst_req ? 32'(wr_burst_addr) : 32'(rd_burst_addr),
                        32'(e.addr));
          end
        end
      end
      prev_wr = wr_burst_req;
      prev_rd = rd_burst_req;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 10'd64,   10'd0,    1'b1, 25'd64};
    vecs[1] = '{1'b1, 10'd63,   10'd0,    1'b0, 25'd0};
    vecs[2] = '{1'b0, 10'd64,   10'd0,    1'b0, 25'd0};
    vecs[3] = '{1'b1, 10'd1023, 10'd1023, 1'b1, 25'd64};
    vecs[4] = '{1'b1, 10'd0,    10'd0,    1'b0, 25'd0};
    vecs[5] = '{1'b1, 10'd65,   10'd448,  1'b1, 25'd64};

    doReset();
    checkOutput("rst_wr_req",  32'(wr_burst_req), 0);
    checkOutput("rst_rd_req",  32'(rd_burst_req), 0);
    checkOutput("rst_wr_addr", 32'(wr_burst_addr), 0);
    checkOutput("rst_rd_addr", 32'(rd_burst_addr), 0);
    checkOutput("rst_stored",  32'(stored_words), 0);
    checkOutput("rst_empty",   32'(mem_empty), 1);
    checkOutput("rst_full",    32'(mem_full), 0);
    checkOutput("rst_busy",    32'(busy), 0);
    checkOutput("rst_tmo",     32'(timeout_err), 0);
    checkOutput("burst_len",   32'(wr_burst_len), 64);

    // Table: start conditions from an empty ring.
    for (int i = 0; i < 6; i++) begin
      doReset();
      eng_delay = 3;
      if (vecs[i].exp_wr) pushExp(1'b1, 0);
      applyStimulus(vecs[i].en, vecs[i].wu, vecs[i].ru);
      @(negedge mem_clk);
      checkOutput($sformatf("vec%0d_wr_req", i), 32'(wr_burst_req), 32'(vecs[i].exp_wr));
      checkOutput($sformatf("vec%0d_rd_req", i), 32'(rd_burst_req), 0);
      enable = 1'b0;
      waitUntil(0, $sformatf("vec%0d_idle", i), 50);
      @(negedge mem_clk);
      checkOutput($sformatf("vec%0d_stored", i), 32'(stored_words), 32'(vecs[i].exp_stored));
    end

    // Single write with req held until finish.
    doReset();
    eng_delay = 4;
    pushExp(1'b1, 0);
    applyStimulus(1'b1, 10'd64, 10'd0);
    waitUntil(1, "sw_req_rise", 10);
    waitUntil(3, "sw_finish", 20);
    checkOutput("sw_req_held", 32'(wr_burst_req), 1);
    enable = 1'b0;
    @(negedge mem_clk);
    checkOutput("sw_req_drop", 32'(wr_burst_req), 0);
    checkOutput("sw_stored",   32'(stored_words), 64);
    checkOutput("sw_wr_addr",  32'(wr_burst_addr), 64);
    checkOutput("sw_busy",     32'(busy), 0);
    checkOutput("sw_empty",    32'(mem_empty), 0);

    // Round-robin: read, write, read, write, read.
    eng_delay = 3;
    pushExp(1'b0, 0);
    pushExp(1'b1, 64);
    pushExp(1'b0, 64);
    pushExp(1'b1, 128);
    pushExp(1'b0, 128);
    enable = 1'b1;
    waitUntil(5, "rr_all_granted", 200);
    enable = 1'b0;
    waitUntil(0, "rr_idle", 50);
    @(negedge mem_clk);
    checkOutput("rr_stored",  32'(stored_words), 0);
    checkOutput("rr_rd_addr", 32'(rd_burst_addr), 192);
    checkOutput("rr_wr_addr", 32'(wr_burst_addr), 192);

    // Fill the ring, wrap the write pointer, then one read frees one write.
    doReset();
    eng_delay = 2;
    for (int k = 0; k < 16; k++) pushExp(1'b1, k * 64);
    applyStimulus(1'b1, 10'd64, 10'd600);
    waitUntil(6, "full_reached", 400);
    repeat (5) @(negedge mem_clk);
    checkOutput("full_flag",    32'(mem_full), 1);
    checkOutput("full_stored",  32'(stored_words), 1024);
    checkOutput("full_wr_wrap", 32'(wr_burst_addr), 0);
    checkOutput("full_no_17th", 32'(busy), 0);
    checkOutput("full_sb",      32'(sb.size()), 0);
    pushExp(1'b0, 0);
    pushExp(1'b1, 0);
    rd_fifo_wrusedw = 10'd0;
    waitUntil(2, "full_rd_rise", 10);
    rd_fifo_wrusedw = 10'd600;
    waitUntil(5, "full_extra_write", 50);
    waitUntil(0, "full_idle2", 50);
    repeat (5) @(negedge mem_clk);
    checkOutput("full_flag2",   32'(mem_full), 1);
    checkOutput("full_stored2", 32'(stored_words), 1024);
    checkOutput("full_wr_addr", 32'(wr_burst_addr), 64);
    checkOutput("full_rd_addr", 32'(rd_burst_addr), 64);

    // Read backpressure at the downstream FIFO limit.
    doReset();
    eng_delay = 3;
    pushExp(1'b1, 0);
    pushExp(1'b1, 64);
    applyStimulus(1'b1, 10'd64, 10'd449);
    waitUntil(5, "bp_two_writes", 100);
    wr_fifo_rdusedw = 10'd0;
    waitUntil(0, "bp_idle", 50);
    repeat (5) @(negedge mem_clk);
    checkOutput("bp_no_rd",   32'(rd_burst_req), 0);
    checkOutput("bp_busy",    32'(busy), 0);
    checkOutput("bp_stored",  32'(stored_words), 128);
    pushExp(1'b0, 0);
    rd_fifo_wrusedw = 10'd448;
    @(negedge mem_clk);
    checkOutput("bp_rd_req",  32'(rd_burst_req), 1);
    enable = 1'b0;
    waitUntil(0, "bp_idle2", 50);
    checkOutput("bp_stored2", 32'(stored_words), 64);

    // Flush in IDLE blocks the start; flush mid-write waits for completion.
    doReset();
    eng_delay = 3;
    applyStimulus(1'b1, 10'd64, 10'd0);
    flush = 1'b1;
    @(negedge mem_clk);
    checkOutput("fl_idle_blocks", 32'(wr_burst_req), 0);
    flush = 1'b0;
    pushExp(1'b1, 0);
    @(negedge mem_clk);
    checkOutput("fl_wr_start", 32'(wr_burst_req), 1);
    flush  = 1'b1;
    enable = 1'b0;
    @(negedge mem_clk);
    flush = 1'b0;
    waitUntil(3, "fl_finish", 20);
    @(negedge mem_clk);
    checkOutput("fl_done_stored",  32'(stored_words), 64);
    checkOutput("fl_done_wr_addr", 32'(wr_burst_addr), 64);
    @(negedge mem_clk);
    checkOutput("fl_clr_stored",  32'(stored_words), 0);
    checkOutput("fl_clr_wr_addr", 32'(wr_burst_addr), 0);
    checkOutput("fl_clr_empty",   32'(mem_empty), 1);

    // Timeout: engine never answers.
    doReset();
    eng_delay = 0;
    pushExp(1'b1, 0);
    applyStimulus(1'b1, 10'd64, 10'd0);
    waitUntil(1, "to_req_rise", 10);
    n = 0;
    while (wr_burst_req && n < 5000) begin
      n++;
      @(negedge mem_clk);
    end
    checkOutput("to_req_cycles", 32'(n), 4095);
    checkOutput("to_err",        32'(timeout_err), 1);
    checkOutput("to_stored",     32'(stored_words), 0);
    checkOutput("to_wr_addr",    32'(wr_burst_addr), 0);
    pushExp(1'b1, 0);
    eng_delay = 3;
    waitUntil(1, "to_retry_rise", 10);
    enable = 1'b0;
    waitUntil(0, "to_retry_idle", 20);
    checkOutput("to_retry_stored", 32'(stored_words), 64);
    checkOutput("to_err_sticky",   32'(timeout_err), 1);

    // Reset mid-read, asserted together with the finish pulse.
    pushExp(1'b0, 0);
    applyStimulus(1'b1, 10'd0, 10'd0);
    waitUntil(2, "mr_rd_rise", 10);
    waitUntil(4, "mr_rd_finish", 20);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge mem_clk);
    checkOutput("mr_rd_req",  32'(rd_burst_req), 0);
    checkOutput("mr_wr_req",  32'(wr_burst_req), 0);
    checkOutput("mr_stored",  32'(stored_words), 0);
    checkOutput("mr_rd_addr", 32'(rd_burst_addr), 0);
    checkOutput("mr_wr_addr", 32'(wr_burst_addr), 0);
    checkOutput("mr_empty",   32'(mem_empty), 1);
    checkOutput("mr_full",    32'(mem_full), 0);
    checkOutput("mr_busy",    32'(busy), 0);
    checkOutput("mr_tmo",     32'(timeout_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge mem_clk);
    checkOutput("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
